// File: rtl/mem_ctrl.sv
// mem_ctrl: block-transfer controller between the cache and main memory.
// Serves one refill and/or writeback request at a time. A dirty miss is
// handled as a single request: the victim is written first, then the block
// is refilled. A programmable idle delay precedes every memory access so the
// cache sees a realistic miss penalty.
module mem_ctrl #(
    parameter int MEM_LAT   = 4,
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int BYTE      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // cache request channel
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rd,
    input  logic                 req_wb,
    input  logic [PA_WIDTH-1:0]  req_addr,
    input  logic [PA_WIDTH-1:0]  req_wb_addr,
    input  logic [BLK_WIDTH-1:0] req_wb_data,
    // cache response channel
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BLK_WIDTH-1:0] resp_data,
    output logic [PA_WIDTH-1:0]  resp_addr,
    output logic                 wb_done,
    // memory port
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data
);

    localparam int BLK_BYTES = BLK_WIDTH / BYTE;
    localparam int OFS       = $clog2(BLK_BYTES);
    localparam int CNT_W     = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // Clears the byte offset so every memory access is block aligned.
    localparam logic [PA_WIDTH-1:0] ALIGN_MASK =
        {{(PA_WIDTH - OFS){1'b1}}, {OFS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_DLY,
        S_WB_ISSUE,
        S_RD_DLY,
        S_RD_ISSUE,
        S_RD_CAP,
        S_RESP
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    logic                 rd_q;
    logic                 wb_q;
    logic [PA_WIDTH-1:0]  rd_addr_q;
    logic [PA_WIDTH-1:0]  wb_addr_q;
    logic [BLK_WIDTH-1:0] wb_data_q;
    logic [BLK_WIDTH-1:0] resp_data_q;

    logic                 accept;

    function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] a);
        blk_align = a & ALIGN_MASK;
    endfunction

    assign accept = req_valid && (state == S_IDLE);

    // State and delay counter register; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; with MEM_LAT==0 the delay states are bypassed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_wb) begin
                        state_nxt = (MEM_LAT == 0) ? S_WB_ISSUE : S_WB_DLY;
                        cnt_nxt   = LAT_C;
                    end else if (req_rd) begin
                        state_nxt = (MEM_LAT == 0) ? S_RD_ISSUE : S_RD_DLY;
                        cnt_nxt   = LAT_C;
                    end
                end
            end
            S_WB_DLY: begin
                cnt_nxt = cnt - ONE_C;
                if (cnt <= ONE_C) begin
                    state_nxt = S_WB_ISSUE;
                end
            end
            S_WB_ISSUE: begin
                if (rd_q) begin
                    state_nxt = (MEM_LAT == 0) ? S_RD_ISSUE : S_RD_DLY;
                    cnt_nxt   = LAT_C;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD_DLY: begin
                cnt_nxt = cnt - ONE_C;
                if (cnt <= ONE_C) begin
                    state_nxt = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: state_nxt = S_RD_CAP;
            S_RD_CAP:   state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Request latch: everything the transfer needs is captured on accept,
    // so the cache may change req_* freely while the controller is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= 1'b0;
            wb_q      <= 1'b0;
            rd_addr_q <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            rd_q      <= req_rd;
            wb_q      <= req_wb;
            rd_addr_q <= req_addr;
            wb_addr_q <= req_wb_addr;
            wb_data_q <= req_wb_data;
        end
    end

    // Refill capture: mem returns data one edge after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q <= '0;
        end else if (state == S_RD_CAP) begin
            resp_data_q <= mem_rd_data;
        end
    end

    // Output decode straight from state so reset drops strobes immediately.
    always_comb begin
        req_ready   = (state == S_IDLE);
        resp_valid  = (state == S_RESP);
        resp_data   = resp_data_q;
        resp_addr   = blk_align(rd_addr_q);
        mem_wr_en   = (state == S_WB_ISSUE) && wb_q;
        wb_done     = mem_wr_en;
        mem_rd_en   = (state == S_RD_ISSUE);
        mem_addr    = '0;
        mem_wr_data = '0;
        if (mem_wr_en) begin
            mem_addr    = blk_align(wb_addr_q);
            mem_wr_data = wb_data_q;
        end else if (mem_rd_en) begin
            mem_addr    = blk_align(rd_addr_q);
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: three controllers (MEM_LAT = 4, 2, 0) each with its own
// behavioural memory. A cycle-timeline model predicts every output on every
// cycle; directed tests add hand-computed literal expectations.
module tb_mem_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic         req_valid   [N];
    logic         req_ready   [N];
    logic         req_rd      [N];
    logic         req_wb      [N];
    logic [31:0]  req_addr    [N];
    logic [31:0]  req_wb_addr [N];
    logic [511:0] req_wb_data [N];
    logic         resp_valid  [N];
    logic         resp_ready  [N];
    logic [511:0] resp_data   [N];
    logic [31:0]  resp_addr   [N];
    logic         wb_done     [N];
    logic [31:0]  mem_addr    [N];
    logic         mem_rd_en   [N];
    logic         mem_wr_en   [N];
    logic [511:0] mem_wr_data [N];
    logic [511:0] mem_rd_data [N];

    int n_chk = 0;
    int n_err = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_ctrl #(
            .MEM_LAT  ((g == 0) ? 4 : ((g == 1) ? 2 : 0)),
            .PA_WIDTH (32),
            .BLK_WIDTH(512),
            .BYTE     (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_rd     (req_rd[g]),
            .req_wb     (req_wb[g]),
            .req_addr   (req_addr[g]),
            .req_wb_addr(req_wb_addr[g]),
            .req_wb_data(req_wb_data[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .resp_addr  (resp_addr[g]),
            .wb_done    (wb_done[g]),
            .mem_addr   (mem_addr[g]),
            .mem_rd_en  (mem_rd_en[g]),
            .mem_wr_en  (mem_wr_en[g]),
            .mem_wr_data(mem_wr_data[g]),
            .mem_rd_data(mem_rd_data[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 0);
    endfunction

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:6], 6'b0};
    endfunction

    function automatic logic [63:0] mkey(input int i, input logic [31:0] a);
        return {i, al(a)};
    endfunction

    // Initial memory contents: each block holds a pattern derived from its address.
    function automatic logic [511:0] blk_init(input logic [31:0] a);
        return {16{al(a) ^ 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory environment driven by the DUT strobes.
    logic [511:0] env_mem [logic [63:0]];

    function automatic logic [511:0] env_rd(input int i, input logic [31:0] a);
        if (env_mem.exists(mkey(i, a))) return env_mem[mkey(i, a)];
        return blk_init(a);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_wr_en[i] === 1'b1) env_mem[mkey(i, mem_addr[i])] = mem_wr_data[i];
            if (mem_rd_en[i] === 1'b1) mem_rd_data[i] <= env_rd(i, mem_addr[i]);
        end
    end

    // Reference model: transaction timeline relative to the accept cycle.
    logic [511:0] model_mem [logic [63:0]];
    bit           busy [N];
    int           d    [N];
    bit           m_rd [N];
    bit           m_wb [N];
    logic [31:0]  m_ra [N];
    logic [31:0]  m_wa [N];
    logic [511:0] m_wd [N];
    logic [511:0] m_exp[N];

    function automatic logic [511:0] model_rd(input int i, input logic [31:0] a);
        if (model_mem.exists(mkey(i, a))) return model_mem[mkey(i, a)];
        return blk_init(a);
    endfunction

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int L, rcyc;
        bit e_wr, e_rd, e_rv;
        for (int i = 0; i < N; i++) begin
            L = lat_of(i);
            if (!rst_n) begin
                chk("rst_req_ready", 512'(req_ready[i]), 512'd1);
                chk("rst_resp_valid", 512'(resp_valid[i]), 512'd0);
                chk("rst_strobes", 512'({mem_rd_en[i], mem_wr_en[i], wb_done[i]}), 512'd0);
                chk("rst_resp_data", resp_data[i], 512'd0);
                chk("rst_addrs", 512'({resp_addr[i], mem_addr[i]}), 512'd0);
                chk("rst_wr_data", mem_wr_data[i], 512'd0);
                busy[i] = 1'b0;
            end else begin
                e_wr = 1'b0;
                e_rd = 1'b0;
                e_rv = 1'b0;
                rcyc = 0;
                if (busy[i]) begin
                    rcyc = (m_wb[i] ? L + 1 : 0) + L + 1;
                    if (m_wb[i] && d[i] == L + 1) e_wr = 1'b1;
                    if (m_rd[i] && d[i] == rcyc) e_rd = 1'b1;
                    if (m_rd[i] && d[i] >= rcyc + 2) e_rv = 1'b1;
                end
                chk("m_req_ready", 512'(req_ready[i]), 512'(!busy[i]));
                chk("m_resp_valid", 512'(resp_valid[i]), 512'(e_rv));
                chk("m_wr_en", 512'(mem_wr_en[i]), 512'(e_wr));
                chk("m_wb_done", 512'(wb_done[i]), 512'(e_wr));
                chk("m_rd_en", 512'(mem_rd_en[i]), 512'(e_rd));
                if (e_wr) begin
                    chk("m_wr_addr", 512'(mem_addr[i]), 512'(al(m_wa[i])));
                    chk("m_wr_data", mem_wr_data[i], m_wd[i]);
                    model_mem[mkey(i, m_wa[i])] = m_wd[i];
                end
                if (e_rd) begin
                    chk("m_rd_addr", 512'(mem_addr[i]), 512'(al(m_ra[i])));
                    m_exp[i] = model_rd(i, m_ra[i]);
                end
                if (e_rv) begin
                    chk("m_resp_data", resp_data[i], m_exp[i]);
                    chk("m_resp_addr", 512'(resp_addr[i]), 512'(al(m_ra[i])));
                end
                if (busy[i]) begin
                    if ((e_wr && !m_rd[i]) || (e_rv && resp_ready[i])) busy[i] = 1'b0;
                    else d[i] = d[i] + 1;
                end else if (req_valid[i] && (req_rd[i] || req_wb[i])) begin
                    busy[i] = 1'b1;
                    d[i]    = 1;
                    m_rd[i] = req_rd[i];
                    m_wb[i] = req_wb[i];
                    m_ra[i] = req_addr[i];
                    m_wa[i] = req_wb_addr[i];
                    m_wd[i] = req_wb_data[i];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic wait_to(input int n);
        while (cur < n) step();
    endtask

    // Present a request in the current cycle (cycle 0) and drop it next cycle.
    task automatic issue(input int i, input bit rd, input bit wb, input logic [31:0] ra,
                         input logic [31:0] wa, input logic [511:0] wd);
        req_valid[i]   = 1'b1;
        req_rd[i]      = rd;
        req_wb[i]      = wb;
        req_addr[i]    = ra;
        req_wb_addr[i] = wa;
        req_wb_data[i] = wd;
        cur = 0;
        step();
        req_valid[i] = 1'b0;
        req_rd[i]    = 1'b0;
        req_wb[i]    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]   = 1'b0;
            req_rd[i]      = 1'b0;
            req_wb[i]      = 1'b0;
            req_addr[i]    = '0;
            req_wb_addr[i] = '0;
            req_wb_data[i] = '0;
            resp_ready[i]  = 1'b1;
            busy[i]        = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 512'(req_ready[0]), 512'd1);
        chk("reset_resp_valid", 512'(resp_valid[1]), 512'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Refill only, L=4
        issue(0, 1, 0, 32'h0000_0123, 32'h0, 512'h0);
        wait_to(5);
        chk("t1_rd_en_c5", 512'(mem_rd_en[0]), 512'd1);
        chk("t1_mem_addr", 512'(mem_addr[0]), 512'h100);
        wait_to(6);
        chk("t1_resp_c6", 512'(resp_valid[0]), 512'd0);
        wait_to(7);
        chk("t1_resp_c7", 512'(resp_valid[0]), 512'd1);
        chk("t1_resp_data", resp_data[0], {16{32'hC0DE_0100}});
        chk("t1_resp_addr", 512'(resp_addr[0]), 512'h100);
        wait_to(8);
        chk("t1_ready_c8", 512'(req_ready[0]), 512'd1);

        // Dirty miss, L=2
        issue(1, 1, 1, 32'h0000_0080, 32'h0000_0240, {64{8'hAB}});
        wait_to(3);
        chk("t2_wr_en_c3", 512'(mem_wr_en[1]), 512'd1);
        chk("t2_wb_done_c3", 512'(wb_done[1]), 512'd1);
        chk("t2_wr_addr", 512'(mem_addr[1]), 512'h240);
        wait_to(6);
        chk("t2_rd_en_c6", 512'(mem_rd_en[1]), 512'd1);
        chk("t2_rd_addr", 512'(mem_addr[1]), 512'h080);
        wait_to(8);
        chk("t2_resp_c8", 512'(resp_valid[1]), 512'd1);
        chk("t2_resp_data", resp_data[1], {16{32'hC0DE_0080}});
        step();
        issue(1, 1, 0, 32'h0000_0255, 32'h0, 512'h0);
        wait_to(5);
        chk("t2_reread_data", resp_data[1], {64{8'hAB}});
        chk("t2_reread_addr", 512'(resp_addr[1]), 512'h240);
        step();

        // Backpressure, L=4
        resp_ready[0] = 1'b0;
        issue(0, 1, 0, 32'h0000_01C7, 32'h0, 512'h0);
        wait_to(7);
        for (int k = 0; k < 10; k++) begin
            chk("t3_hold_valid", 512'(resp_valid[0]), 512'd1);
            chk("t3_hold_data", resp_data[0], {16{32'hC0DE_01C0}});
            chk("t3_busy", 512'(req_ready[0]), 512'd0);
            req_valid[0]   = (k == 3);
            req_wb[0]      = (k == 3);
            req_wb_addr[0] = 32'h0000_0900;
            step();
        end
        req_valid[0]  = 1'b0;
        req_wb[0]     = 1'b0;
        resp_ready[0] = 1'b1;
        chk("t3_still_valid", 512'(resp_valid[0]), 512'd1);
        step();
        chk("t3_ready_after", 512'(req_ready[0]), 512'd1);
        repeat (8) step();
        chk("t3_no_wb_pulse", env_rd(0, 32'h900), {16{32'hC0DE_0900}});

        // L=0 refill, back-to-back
        req_valid[2] = 1'b1;
        req_rd[2]    = 1'b1;
        req_addr[2]  = 32'h0000_1000;
        cur = 0;
        while (cur < 10) begin
            step();
            req_addr[2] = 32'h0000_1000 + 32'(cur) * 32'h40;
            if (cur == 1) begin
                chk("t4_rd_en_c1", 512'(mem_rd_en[2]), 512'd1);
                chk("t4_addr_c1", 512'(mem_addr[2]), 512'h1000);
            end
            if (cur == 3) chk("t4_resp_c3", resp_data[2], {16{32'hC0DE_1000}});
            if (cur == 4) chk("t4_ready_c4", 512'(req_ready[2]), 512'd1);
            if (cur == 5) chk("t4_addr_c5", 512'(mem_addr[2]), 512'h1100);
            if (cur == 7) chk("t4_resp_c7", resp_data[2], {16{32'hC0DE_1100}});
            if (cur == 8) chk("t4_ready_c8", 512'(req_ready[2]), 512'd1);
        end
        req_valid[2] = 1'b0;
        req_rd[2]    = 1'b0;
        wait_to(13);

        // L=0 writeback only, then same-block writeback+refill
        issue(2, 0, 1, 32'h0, 32'h0000_2000, {16{32'h1234_5678}});
        chk("t4_wb_c1", 512'(mem_wr_en[2]), 512'd1);
        step();
        chk("t4_wb_ready_c2", 512'(req_ready[2]), 512'd1);
        issue(2, 1, 1, 32'h0000_3010, 32'h0000_3010, {64{8'h77}});
        wait_to(4);
        chk("t4_raw_valid", 512'(resp_valid[2]), 512'd1);
        chk("t4_raw_data", resp_data[2], {64{8'h77}});
        step();

        // Empty request
        issue(1, 0, 0, 32'h0000_0500, 32'h0000_0540, {64{8'h11}});
        chk("t5_ready", 512'(req_ready[1]), 512'd1);
        chk("t5_no_strobe", 512'({mem_rd_en[1], mem_wr_en[1]}), 512'd0);
        repeat (5) step();
        chk("t5_no_resp", 512'(resp_valid[1]), 512'd0);

        // Reset during WB_DLY of a dirty miss
        issue(1, 1, 1, 32'h0000_0380, 32'h0000_0300, {64{8'h5A}});
        #1 rst_n = 1'b0;
        #1;
        chk("t6_wr_en_now", 512'(mem_wr_en[1]), 512'd0);
        chk("t6_ready_now", 512'(req_ready[1]), 512'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) step();
        chk("t6_ready_after", 512'(req_ready[1]), 512'd1);
        chk("t6_resp_after", 512'(resp_valid[1]), 512'd0);
        chk("t6_mem_unchanged", env_rd(1, 32'h300), {16{32'hC0DE_0300}});

        // Reset while a response is pending
        resp_ready[0] = 1'b0;
        issue(0, 1, 0, 32'h0000_0400, 32'h0, 512'h0);
        wait_to(8);
        chk("t7_resp_pending", 512'(resp_valid[0]), 512'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_resp_dropped", 512'(resp_valid[0]), 512'd0);
        chk("t7_data_cleared", resp_data[0], 512'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        resp_ready[0] = 1'b1;
        repeat (3) step();
        chk("t7_ready_after", 512'(req_ready[0]), 512'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
